dma_copy_master: RTL

DMA_COPY_MASTER -- requirements
Module: dma_copy_master

---
 rtl/dma_copy_master.sv | 133 +++++++++++++
 1 files changed

// File: rtl/dma_copy_master.sv
// Single-outstanding word copy engine: read one word from src, write it to dst, repeat len times.
// Each word takes RD_REQ/RD_WAIT, RD_GAP, WR_REQ/WR_WAIT, WR_GAP; a bus error ends the copy early.
module dma_copy_master #(
  parameter int LEN_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [31:0]      src_addr,
  input  logic [31:0]      dst_addr,
  input  logic [LEN_W-1:0] len,
  output logic             busy,
  output logic             done,
  output logic             err,
  output logic             req,
  output logic             we,
  output logic [3:0]       be,
  output logic [31:0]      addr,
  output logic [31:0]      wdata,
  input  logic             gnt,
  input  logic             rvalid,
  input  logic [31:0]      rdata,
  input  logic             bus_err
);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    RD_REQ  = 3'd1,
    RD_WAIT = 3'd2,
    RD_GAP  = 3'd3,
    WR_REQ  = 3'd4,
    WR_WAIT = 3'd5,
    WR_GAP  = 3'd6,
    DONE    = 3'd7
  } state_t;

  state_t           state_q, state_d;
  logic [31:0]      src_q, src_d;
  logic [31:0]      dst_q, dst_d;
  logic [31:0]      data_q, data_d;
  logic [LEN_W-1:0] cnt_q, cnt_d;
  logic             err_q, err_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      src_q   <= '0;
      dst_q   <= '0;
      data_q  <= '0;
      cnt_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      src_q   <= src_d;
      dst_q   <= dst_d;
      data_q  <= data_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
    end
  end

  always_comb begin
    state_d = state_q;
    src_d   = src_q;
    dst_d   = dst_q;
    data_d  = data_q;
    cnt_d   = cnt_q;
    err_d   = err_q;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          err_d = 1'b0;
          if (len != '0) begin
            src_d   = {src_addr[31:2], 2'b00};
            dst_d   = {dst_addr[31:2], 2'b00};
            cnt_d   = len;
            state_d = RD_REQ;
          end else begin
            state_d = DONE;
          end
        end
      end
      RD_REQ, RD_WAIT: begin
        // A response is only accepted once the request has been granted.
        if ((state_q == RD_WAIT || gnt) && rvalid) begin
          if (bus_err) begin
            err_d   = 1'b1;
            state_d = DONE;
          end else begin
            data_d  = rdata;
            state_d = RD_GAP;
          end
        end else if (state_q == RD_REQ && gnt) begin
          state_d = RD_WAIT;
        end
      end
      RD_GAP: state_d = WR_REQ;
      WR_REQ, WR_WAIT: begin
        if ((state_q == WR_WAIT || gnt) && rvalid) begin
          if (bus_err) begin
            err_d   = 1'b1;
            state_d = DONE;
          end else begin
            state_d = WR_GAP;
          end
        end else if (state_q == WR_REQ && gnt) begin
          state_d = WR_WAIT;
        end
      end
      WR_GAP: begin
        src_d   = src_q + 32'd4;
        dst_d   = dst_q + 32'd4;
        cnt_d   = cnt_q - LEN_W'(1);
        state_d = (cnt_q == LEN_W'(1)) ? DONE : RD_REQ;
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Bus outputs decode straight from registered state, so they are held for the whole request.
  always_comb begin
    req   = (state_q == RD_REQ) || (state_q == WR_REQ);
    we    = (state_q == WR_REQ);
    be    = req ? 4'hF : 4'h0;
    addr  = (state_q == RD_REQ) ? src_q : (state_q == WR_REQ) ? dst_q : 32'd0;
    wdata = (state_q == WR_REQ) ? data_q : 32'd0;
    busy  = (state_q != IDLE);
    done  = (state_q == DONE);
    err   = err_q;
  end

endmodule
